// File: rtl/lcd_pkg.sv
// Shared types, timing defaults and configuration table for the 4-bit LCD bus sequencer.
package lcd_pkg;

    localparam int unsigned T_EN_DEF  = 12;
    localparam int unsigned T_NIB_DEF = 50;
    localparam int unsigned T_CMD_DEF = 2000;
    localparam int unsigned T_CLR_DEF = 82000;
    localparam int unsigned CNT_W_DEF = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_CFG,
        S_BUSY,
        S_READY
    } seq_state_t;

    typedef enum logic [2:0] {
        S_TX_IDLE,
        S_HI_EN,
        S_GAP,
        S_LO_EN,
        S_SETTLE
    } tx_state_t;

    // Entry 0 is sent first: function set, entry mode, display on, clear.
    localparam logic [3:0][7:0] CFG_ROM = {8'h01, 8'h0C, 8'h06, 8'h28};
    localparam logic [2:0]      CFG_LEN = 3'd4;

    // Clear (0x01) and home (0x02) need the long settle; 0x00 falls in the same bucket.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data <= 8'h02);
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Serialises one byte as two E-strobed nibbles followed by a command settle delay.
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int unsigned T_EN  = T_EN_DEF,
    parameter int unsigned T_NIB = T_NIB_DEF,
    parameter int unsigned T_CMD = T_CMD_DEF,
    parameter int unsigned T_CLR = T_CLR_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       done,
    output logic       e,
    output logic       rs_out,
    output logic [3:0] d
);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       data_q;

    // Each phase loads N-1 on entry and leaves on zero, giving exactly N cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_TX_IDLE;
            cnt    <= '0;
            data_q <= '0;
            rs_out <= '0;
            e      <= '0;
            d      <= '0;
        end else begin
            case (state)
                S_TX_IDLE: begin
                    if (start) begin
                        state  <= S_HI_EN;
                        cnt    <= CNT_W'(T_EN - 1);
                        data_q <= data;
                        rs_out <= rs;
                        e      <= 1'b1;
                        d      <= data[7:4];
                    end
                end
                S_HI_EN: begin
                    if (cnt == '0) begin
                        state <= S_GAP;
                        cnt   <= CNT_W'(T_NIB - 1);
                        e     <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        state <= S_LO_EN;
                        cnt   <= CNT_W'(T_EN - 1);
                        e     <= 1'b1;
                        d     <= data_q[3:0];
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_LO_EN: begin
                    if (cnt == '0) begin
                        state <= S_SETTLE;
                        cnt   <= is_long_cmd(rs_out, data_q) ? CNT_W'(T_CLR - 1) : CNT_W'(T_CMD - 1);
                        e     <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        state  <= S_TX_IDLE;
                        rs_out <= 1'b0;
                        d      <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= S_TX_IDLE;
            endcase
        end
    end

    assign done = (state == S_SETTLE) && (cnt == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// LCD bus owner: runs the init FSM handshake, sends the configuration table, then serves byte writes.
module lcd_bus_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned T_EN  = T_EN_DEF,
    parameter int unsigned T_NIB = T_NIB_DEF,
    parameter int unsigned T_CMD = T_CMD_DEF,
    parameter int unsigned T_CLR = T_CLR_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    output logic       INI,
    input  logic       INILISTO,
    input  logic [4:0] SF_ENDINI,
    input  logic       WR_REQ,
    input  logic       WR_RS,
    input  logic [7:0] WR_DATA,
    output logic       WR_ACK,
    output logic       READY,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [3:0] SF_D
);

    seq_state_t state;
    logic [2:0] idx;
    logic       tx_start;
    logic       tx_rs;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       tx_e;
    logic       tx_rs_out;
    logic [3:0] tx_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            idx   <= '0;
            INI   <= '0;
            READY <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state <= S_INIT;
                        INI   <= 1'b1;
                    end
                end
                S_INIT: begin
                    if (INILISTO) begin
                        state <= S_CFG;
                        INI   <= 1'b0;
                    end
                end
                S_CFG: begin
                    idx   <= idx + 3'd1;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    if (tx_done) begin
                        if (idx < CFG_LEN) begin
                            state <= S_CFG;
                        end else begin
                            state <= S_READY;
                            READY <= 1'b1;
                        end
                    end
                end
                S_READY: begin
                    if (WR_REQ) begin
                        state <= S_BUSY;
                        READY <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Acknowledge is combinational so the requester sees it in the accepting cycle.
    always_comb begin
        tx_start = 1'b0;
        tx_rs    = 1'b0;
        tx_data  = '0;
        WR_ACK   = 1'b0;
        if (state == S_CFG) begin
            tx_start = 1'b1;
            tx_data  = CFG_ROM[idx[1:0]];
        end else if (state == S_READY && WR_REQ) begin
            tx_start = 1'b1;
            tx_rs    = WR_RS;
            tx_data  = WR_DATA;
            WR_ACK   = 1'b1;
        end
    end

    lcd_nibble_tx #(
        .T_EN  (T_EN),
        .T_NIB (T_NIB),
        .T_CMD (T_CMD),
        .T_CLR (T_CLR),
        .CNT_W (CNT_W)
    ) u_tx (
        .CLK    (CLK),
        .RST    (RST),
        .start  (tx_start),
        .rs     (tx_rs),
        .data   (tx_data),
        .done   (tx_done),
        .e      (tx_e),
        .rs_out (tx_rs_out),
        .d      (tx_d)
    );

    always_comb begin
        LCD_E  = tx_e;
        LCD_RS = tx_rs_out;
        SF_D   = tx_d;
        if (state == S_INIT) begin
            LCD_E  = SF_ENDINI[4];
            LCD_RS = 1'b0;
            SF_D   = SF_ENDINI[3:0];
        end
    end

    assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Randomised self-checking bench: pin-level byte decoder and timing rules versus the sequencer.
module tb_lcd_bus_sequencer;

    localparam int T_EN  = 12;
    localparam int T_NIB = 50;
    localparam int T_CMD = 300;
    localparam int T_CLR = 1000;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       INI;
    logic       INILISTO = 1'b0;
    logic [4:0] SF_ENDINI = '0;
    logic       WR_REQ = 1'b0;
    logic       WR_RS = 1'b0;
    logic [7:0] WR_DATA = '0;
    logic       WR_ACK;
    logic       READY;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [3:0] SF_D;

    int errors = 0;
    int checks = 0;
    int spurious_ack = 0;
    int w_a, w_b;

    lcd_bus_sequencer #(
        .T_EN  (T_EN),
        .T_NIB (T_NIB),
        .T_CMD (T_CMD),
        .T_CLR (T_CLR),
        .CNT_W (17)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .INI       (INI),
        .INILISTO  (INILISTO),
        .SF_ENDINI (SF_ENDINI),
        .WR_REQ    (WR_REQ),
        .WR_RS     (WR_RS),
        .WR_DATA   (WR_DATA),
        .WR_ACK    (WR_ACK),
        .READY     (READY),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .SF_D      (SF_D)
    );

    always #5 CLK = ~CLK;

    // An acknowledge is only legitimate while READY with a request pending.
    always @(negedge CLK) begin
        #2;
        if (WR_ACK === 1'b1 && !(READY === 1'b1 && WR_REQ === 1'b1)) spurious_ack++;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int settle_of(input bit rs, input logic [7:0] b);
        return (!rs && b <= 8'h02) ? T_CLR : T_CMD;
    endfunction

    // Length of the current run of LCD_E==lvl (a low run also ends when READY rises).
    task automatic run_len(input bit lvl, input int exp_len, input bit exp_rs, input logic [3:0] exp_d,
                           output int n, output int bad);
        n = 0;
        bad = 0;
        while (LCD_E === lvl && !(lvl == 1'b0 && READY === 1'b1) && n < exp_len + 100) begin
            if (n < exp_len && (SF_D !== exp_d || LCD_RS !== exp_rs)) bad++;
            n++;
            @(negedge CLK);
        end
    endtask

    // Decodes one byte from the pins and checks its pulse/gap/settle timing.
    task automatic expect_byte(input string tag, input bit rs, input logic [7:0] b,
                               input bit then_cfg, input int exp_wait);
        int w, n, bad, st;
        w = 0;
        while (LCD_E !== 1'b1 && w < 100) begin
            w++;
            @(negedge CLK);
        end
        check({tag, "_e_wait"}, w, exp_wait);
        run_len(1'b1, T_EN, rs, b[7:4], n, bad);
        check({tag, "_hi_len"}, n, T_EN);
        check({tag, "_hi_pins"}, bad, 0);
        run_len(1'b0, T_NIB, rs, b[7:4], n, bad);
        check({tag, "_gap_len"}, n, T_NIB);
        check({tag, "_gap_pins"}, bad, 0);
        run_len(1'b1, T_EN, rs, b[3:0], n, bad);
        check({tag, "_lo_len"}, n, T_EN);
        check({tag, "_lo_pins"}, bad, 0);
        st = settle_of(rs, b);
        run_len(1'b0, st, rs, b[3:0], n, bad);
        check({tag, "_settle_len"}, n, st + (then_cfg ? 1 : 0));
        check({tag, "_settle_pins"}, bad, 0);
    endtask

    task automatic do_write(input bit rs, input logic [7:0] b, output int waited);
        WR_RS = rs;
        WR_DATA = b;
        WR_REQ = 1'b1;
        waited = 0;
        #1;
        while (WR_ACK !== 1'b1 && waited < 5000) begin
            @(negedge CLK);
            #1;
            waited++;
        end
        check("ack_seen", WR_ACK, 1);
        @(posedge CLK);
        #1;
        WR_REQ = 1'b0;
        WR_RS = 1'($urandom);
        WR_DATA = 8'($urandom);
        @(negedge CLK);
        check("ready_drop", READY, 0);
    endtask

    task automatic init_seq();
        int n, bad;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("ini_latency", INI, 1);
        n = 0;
        bad = 0;
        while (INI === 1'b1 && n < 1000) begin
            n++;
            SF_ENDINI = (n == 50) ? 5'b10011 : 5'($urandom);
            #1;
            if ({LCD_E, SF_D} !== SF_ENDINI || LCD_RS !== 1'b0) bad++;
            if (n == 50) check("endini_10011", {LCD_E, SF_D}, 5'h13);
            INILISTO = (n == 100);
            @(negedge CLK);
        end
        INILISTO = 1'b0;
        check("ini_high_cycles", n, 100);
        check("endini_passthru", bad, 0);
    endtask

    task automatic config_seq(input string tag);
        expect_byte({tag, "_cfg28"}, 1'b0, 8'h28, 1'b1, 1);
        expect_byte({tag, "_cfg06"}, 1'b0, 8'h06, 1'b1, 0);
        expect_byte({tag, "_cfg0c"}, 1'b0, 8'h0C, 1'b1, 0);
        expect_byte({tag, "_cfg01"}, 1'b0, 8'h01, 1'b0, 0);
        check({tag, "_ready"}, READY, 1);
    endtask

    initial begin
        bit         rs;
        logic [7:0] b;
        int         e_seen;
        bit         brs [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] bdat [5] = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h01};

        repeat (3) @(negedge CLK);
        check("reset_outputs", {LCD_E, LCD_RS, LCD_RW, SF_D, READY, INI, WR_ACK}, 0);
        RST = 1'b0;
        @(negedge CLK);

        // Strays in IDLE must be ignored.
        INILISTO = 1'b1;
        WR_REQ = 1'b1;
        @(negedge CLK);
        check("idle_ignore", {INI, READY, LCD_E}, 0);
        INILISTO = 1'b0;
        WR_REQ = 1'b0;
        @(negedge CLK);

        init_seq();
        config_seq("a");

        START = 1'b1;
        INILISTO = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        INILISTO = 1'b0;
        @(negedge CLK);
        check("ready_ignore_start", {READY, INI, LCD_E}, 3'b100);

        do_write(1'b1, 8'h41, w_a);
        check("ack_immediate", w_a, 0);
        expect_byte("w41", 1'b1, 8'h41, 1'b0, 0);
        check("w41_ready", READY, 1);

        for (int i = 0; i < 5; i++) begin
            do_write(brs[i], bdat[i], w_a);
            expect_byte($sformatf("bnd%0d", i), brs[i], bdat[i], 1'b0, 0);
        end

        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            do_write(rs, b, w_a);
            expect_byte($sformatf("rnd%0d", i), rs, b, 1'b0, 0);
        end

        // Second request raised while the first is on the bus.
        rs = 1'($urandom_range(0, 1));
        b = 8'($urandom_range(0, 255));
        do_write(1'b0, 8'h02, w_a);
        fork
            do_write(rs, b, w_b);
            expect_byte("b2b_a", 1'b0, 8'h02, 1'b0, 0);
        join
        check("b2b_wait", w_b, 2 * T_EN + T_NIB + T_CLR);
        expect_byte("b2b_b", rs, b, 1'b0, 0);

        // Reset while the low nibble is strobed.
        do_write(1'b1, 8'h5A, w_a);
        repeat (T_EN + T_NIB + 5) @(negedge CLK);
        check("pre_rst_lo_en", {LCD_E, SF_D}, 5'h1A);
        #2;
        RST = 1'b1;
        #1;
        check("rst_async", {LCD_E, LCD_RS, LCD_RW, SF_D, READY, INI, WR_ACK}, 0);
        @(negedge CLK);
        RST = 1'b0;
        WR_REQ = 1'b1;
        e_seen = 0;
        repeat (30) begin
            @(negedge CLK);
            if (LCD_E !== 1'b0 || READY !== 1'b0) e_seen++;
        end
        check("post_rst_quiet", e_seen, 0);
        fork
            do_write(1'b1, 8'hC3, w_a);
            begin
                init_seq();
                config_seq("b");
            end
        join
        expect_byte("post_rst_wr", 1'b1, 8'hC3, 1'b0, 0);

        check("spurious_ack", spurious_ack, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
